// File: rtl/mc_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO: width helpers, the pointer type for
// the default geometry, and threshold clamping used by the per-channel controller.
package mc_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Pointer type for the default 16-deep geometry; parameterised instances size
  // their pointers with ptr_width() instead.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  // $clog2 that never returns 0, so a select of a single item still gets a 1-bit port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A pointer carries one extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  // Keeps a threshold inside 1..depth-1 so a bad parameter cannot pin a flag.
  function automatic int unsigned clamp_th(input int unsigned th, input int unsigned depth);
    if (th < 1) return 1;
    if (th > depth - 1) return depth - 1;
    return th;
  endfunction

endpackage

// File: rtl/mc_fifo_ch_ctrl.sv
// One logical queue's bookkeeping: write/read pointers, the four status flags
// and the occupancy count. Holds no data; the top owns the shared storage.
// Macro MC_FIFO_CNT_EN: when defined the count output is driven, otherwise it is 0.
module mc_fifo_ch_ctrl
  import mc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_acc,
  input  logic                  rd_acc,
  output logic [ADDR_WIDTH-1:0] wptr_lo,
  output logic [ADDR_WIDTH-1:0] rptr_lo,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   cnt
);

  localparam int unsigned PW     = ptr_width(ADDR_WIDTH);
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - clamp_th(AFULL_TH, DEPTH));
  localparam logic [PW-1:0] AE_LVL = PW'(clamp_th(AEMPTY_TH, DEPTH));

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] diff;

  // Advance each pointer by one on an accepted access; wrap is natural modulo 2**PW.
  always_comb begin
    wptr_d = wptr_q + PW'(wr_acc);
    rptr_d = rptr_q + PW'(rd_acc);
  end

  // Pointer registers, cleared asynchronously so the queue empties immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Flags from the pointer difference; every flag is forced high while reset is held.
  always_comb begin
    diff         = wptr_q - rptr_q;
    full         = ~rst_n | ((wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                             (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]));
    empty        = ~rst_n | (wptr_q == rptr_q);
    almost_full  = ~rst_n | (diff >= AF_LVL);
    almost_empty = ~rst_n | (diff <= AE_LVL);
    wptr_lo      = wptr_q[ADDR_WIDTH-1:0];
    rptr_lo      = rptr_q[ADDR_WIDTH-1:0];
`ifdef MC_FIFO_CNT_EN
    cnt          = diff;
`else
    cnt          = '0;
`endif
  end

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel FIFO: NUM_CH logical queues sharing one register array, with a
// single write port and a single read port, each steered by a channel select.
// FWFT_EN picks first-word fall-through (1) or registered one-cycle read (0).
// Macro MC_FIFO_CNT_EN: defined drives per-channel occupancy on cnt, undefined ties cnt to 0.
module mc_fifo
  import mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int AFULL_TH   = 1,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT_EN    = 1,
  localparam int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             wr_en,
  input  logic [CH_W-1:0]                  wr_ch,
  input  logic                             rd_en,
  input  logic [CH_W-1:0]                  rd_ch,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_vld,
  output logic [NUM_CH-1:0]                full,
  output logic [NUM_CH-1:0]                almost_full,
  output logic [NUM_CH-1:0]                empty,
  output logic [NUM_CH-1:0]                almost_empty,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] cnt,
  output logic                             wr_ovf,
  output logic                             rd_udf
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int MEM_D  = NUM_CH * DEPTH;
  localparam int MEM_AW = clog2_min1(MEM_D);
  localparam int CW     = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_D];
  logic [NUM_CH-1:0]     wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] wptr_lo [NUM_CH];
  logic [ADDR_WIDTH-1:0] rptr_lo [NUM_CH];
  logic [MEM_AW-1:0]     wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_ne;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  wr_ovf_q, wr_ovf_d;
  logic                  rd_udf_q, rd_udf_d;

  // One controller per logical queue; each owns its own flags and slice of cnt.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CW-1:0] ch_cnt;
    mc_fifo_ch_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AFULL_TH   (AFULL_TH),
      .AEMPTY_TH  (AEMPTY_TH)
    ) u_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_acc       (wr_acc[g]),
      .rd_acc       (rd_acc[g]),
      .wptr_lo      (wptr_lo[g]),
      .rptr_lo      (rptr_lo[g]),
      .full         (full[g]),
      .almost_full  (almost_full[g]),
      .empty        (empty[g]),
      .almost_empty (almost_empty[g]),
      .cnt          (ch_cnt)
    );
    assign cnt[g*CW +: CW] = ch_cnt;
  end

  // Decode channel selects into per-channel accepts and shared-array addresses;
  // a select that matches no channel is never accepted.
  always_comb begin
    wr_acc = '0;
    rd_acc = '0;
    wr_idx = '0;
    rd_idx = '0;
    rd_ne  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_W'(i)) begin
        wr_acc[i] = wr_en & ~full[i];
        wr_idx    = MEM_AW'(i * DEPTH) + MEM_AW'(wptr_lo[i]);
      end
      if (rd_ch == CH_W'(i)) begin
        rd_acc[i] = rd_en & ~empty[i];
        rd_idx    = MEM_AW'(i * DEPTH) + MEM_AW'(rptr_lo[i]);
        rd_ne     = ~empty[i];
      end
    end
  end

  assign head = mem_q[rd_idx];

  // Shared storage; not reset, since the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (|wr_acc) mem_q[wr_idx] <= din;
  end

  // Next state of the read-data holder and the rejection strobes.
  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (|rd_acc) begin
      dout_d     = head;
      dout_vld_d = 1'b1;
    end
    wr_ovf_d = wr_en & ~(|wr_acc);
    rd_udf_d = rd_en & ~(|rd_acc);
  end

  // Output-side registers: last popped word, pop strobe and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      wr_ovf_q   <= 1'b0;
      rd_udf_q   <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      wr_ovf_q   <= wr_ovf_d;
      rd_udf_q   <= rd_udf_d;
    end
  end

  // Fall-through shows the selected head directly, falling back to the last popped word.
  if (FWFT_EN != 0) begin : g_fwft
    assign dout     = rd_ne ? head : dout_q;
    assign dout_vld = rd_ne;
  end else begin : g_reg
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
  end

  assign wr_ovf = wr_ovf_q;
  assign rd_udf = rd_udf_q;

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo: a fall-through and a registered-read instance
// share stimulus and are compared against a queue-based reference model.
module tb_mc_fifo;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din   = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [1:0] rd_ch = '0;

  logic [7:0]  dout, r_dout;
  logic        dout_vld, r_dout_vld;
  logic [3:0]  full, almost_full, empty, almost_empty;
  logic [3:0]  r_full, r_almost_full, r_empty, r_almost_empty;
  logic [19:0] cnt, r_cnt;
  logic        wr_ovf, rd_udf, r_wr_ovf, r_rd_udf;

  mc_fifo #(.FWFT_EN(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_ch(wr_ch),
    .rd_en(rd_en), .rd_ch(rd_ch), .dout(dout), .dout_vld(dout_vld),
    .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .cnt(cnt), .wr_ovf(wr_ovf), .rd_udf(rd_udf)
  );

  mc_fifo #(.FWFT_EN(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_ch(wr_ch),
    .rd_en(rd_en), .rd_ch(rd_ch), .dout(r_dout), .dout_vld(r_dout_vld),
    .full(r_full), .almost_full(r_almost_full), .empty(r_empty),
    .almost_empty(r_almost_empty), .cnt(r_cnt), .wr_ovf(r_wr_ovf), .rd_udf(r_rd_udf)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the registered side outputs.
  logic [7:0] mq [NCH][$];
  logic [7:0] m_last;
  logic       m_vld_r, m_ovf, m_udf;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [15:0] m_flags();
    logic [3:0] f, af, e, ae;
    for (int i = 0; i < NCH; i++) begin
      f[i]  = (mq[i].size() == DEPTH);
      af[i] = (mq[i].size() >= DEPTH - 1);
      e[i]  = (mq[i].size() == 0);
      ae[i] = (mq[i].size() <= 1);
    end
    return {f, af, e, ae};
  endfunction

  function automatic logic [19:0] m_cnt();
    logic [19:0] r;
    r = '0;
`ifdef MC_FIFO_CNT_EN
    for (int i = 0; i < NCH; i++) r[i*5 +: 5] = 5'(mq[i].size());
`endif
    return r;
  endfunction

  function automatic logic [7:0] m_fwft_dout();
    int rc;
    rc = int'(rd_ch);
    return (mq[rc].size() > 0) ? mq[rc][0] : m_last;
  endfunction

  function automatic logic m_fwft_vld();
    return mq[int'(rd_ch)].size() > 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_last  = '0;
    m_vld_r = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Drive one cycle, update the model at the edge from pre-edge occupancy, return #1 later.
  task automatic clk_cycle(input logic we, input int wc, input logic [7:0] d,
                           input logic re, input int rc);
    bit wa, ra;
    wr_en = we; wr_ch = 2'(wc); din = d; rd_en = re; rd_ch = 2'(rc);
    @(posedge clk);
    wa = we && (mq[wc].size() < DEPTH);
    ra = re && (mq[rc].size() > 0);
    if (ra) m_last = mq[rc].pop_front();
    m_vld_r = ra;
    if (wa) mq[wc].push_back(d);
    m_ovf = we && !wa;
    m_udf = re && !ra;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_cycle(1'b0, 0, 8'h00, 1'b0, int'(rd_ch));
  endtask

  task automatic drain_all();
    for (int c = 0; c < NCH; c++)
      while (mq[c].size() > 0) clk_cycle(1'b0, 0, 8'h00, 1'b1, c);
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++; if ({full, almost_full, empty, almost_empty} !== 16'hFFFF) begin n_err++; $display("FAIL rst_hold_flags: got %h want %h", {full, almost_full, empty, almost_empty}, 16'hFFFF); end
    n_vec++; if (cnt !== 20'h0) begin n_err++; $display("FAIL rst_hold_cnt: got %h want 0", cnt); end
    n_vec++; if ({dout, dout_vld, r_dout, r_dout_vld} !== 18'h0) begin n_err++; $display("FAIL rst_hold_dout: got %h want 0", {dout, dout_vld, r_dout, r_dout_vld}); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(1);
    n_vec++; if ({full, almost_full, empty, almost_empty} !== 16'h00FF) begin n_err++; $display("FAIL rst_idle_flags: got %h want %h", {full, almost_full, empty, almost_empty}, 16'h00FF); end
    n_vec++; if (cnt !== 20'h0) begin n_err++; $display("FAIL rst_idle_cnt: got %h want 0", cnt); end
    n_vec++; if ({dout, wr_ovf, rd_udf} !== 10'h0) begin n_err++; $display("FAIL rst_idle_out: got %h want 0", {dout, wr_ovf, rd_udf}); end
  endtask

  task automatic test_fill_ch2();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      clk_cycle(1'b1, 2, 8'(160 + i), 1'b0, 2);
      if (i == 14) begin
        n_vec++; if ({full, almost_full} !== 8'b0000_0100) begin n_err++; $display("FAIL fill_afull15: got %b want %b", {full, almost_full}, 8'b0000_0100); end
      end
    end
    n_vec++; if ({full, empty} !== 8'b0100_1011) begin n_err++; $display("FAIL fill_full16: got %b want %b", {full, empty}, 8'b0100_1011); end
`ifdef MC_FIFO_CNT_EN
    n_vec++; if (cnt[10 +: 5] !== 5'd16) begin n_err++; $display("FAIL fill_cnt: got %0d want 16", cnt[10 +: 5]); end
`else
    n_vec++; if (cnt !== 20'h0) begin n_err++; $display("FAIL fill_cnt: got %h want 0", cnt); end
`endif
    n_vec++; if ({dout, dout_vld} !== {8'hA0, 1'b1}) begin n_err++; $display("FAIL fill_head: got %h/%b want a0/1", dout, dout_vld); end
    clk_cycle(1'b1, 2, 8'hFF, 1'b0, 2);
    n_vec++; if ({wr_ovf, full} !== 5'b1_0100) begin n_err++; $display("FAIL fill_ovf: got %b want %b", {wr_ovf, full}, 5'b1_0100); end
    idle(1);
    n_vec++; if (wr_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_pulse: got %b want 0", wr_ovf); end
    for (int i = 0; i < 16; i++) begin
      exp = 8'(160 + i);
      n_vec++; if (dout !== exp) begin n_err++; $display("FAIL drain_fwft: got %h want %h", dout, exp); end
      clk_cycle(1'b0, 0, 8'h00, 1'b1, 2);
      n_vec++; if ({r_dout, r_dout_vld} !== {exp, 1'b1}) begin n_err++; $display("FAIL drain_reg: got %h/%b want %h/1", r_dout, r_dout_vld, exp); end
    end
    n_vec++; if ({dout, dout_vld, empty} !== {8'hAF, 1'b0, 4'hF}) begin n_err++; $display("FAIL drain_end: got %h want %h", {dout, dout_vld, empty}, {8'hAF, 1'b0, 4'hF}); end
  endtask

  task automatic test_interleave();
    clk_cycle(1'b1, 0, 8'h11, 1'b0, 0);
    clk_cycle(1'b1, 1, 8'h22, 1'b0, 0);
    clk_cycle(1'b1, 0, 8'h33, 1'b0, 0);
    n_vec++; if ({dout, dout_vld} !== {8'h11, 1'b1}) begin n_err++; $display("FAIL il_head0: got %h/%b want 11/1", dout, dout_vld); end
    clk_cycle(1'b0, 0, 8'h00, 1'b1, 0);
    n_vec++; if ({dout, r_dout, r_dout_vld} !== {8'h33, 8'h11, 1'b1}) begin n_err++; $display("FAIL il_pop1: got %h want %h", {dout, r_dout, r_dout_vld}, {8'h33, 8'h11, 1'b1}); end
    clk_cycle(1'b0, 0, 8'h00, 1'b1, 0);
    n_vec++; if ({empty, dout, dout_vld, r_dout} !== {4'b1101, 8'h33, 1'b0, 8'h33}) begin n_err++; $display("FAIL il_pop2: got %h want %h", {empty, dout, dout_vld, r_dout}, {4'b1101, 8'h33, 1'b0, 8'h33}); end
    idle(1);
    n_vec++; if ({r_dout, r_dout_vld} !== {8'h33, 1'b0}) begin n_err++; $display("FAIL il_reg_hold: got %h/%b want 33/0", r_dout, r_dout_vld); end
    clk_cycle(1'b0, 0, 8'h00, 1'b0, 1);
    n_vec++; if (dout !== 8'h22) begin n_err++; $display("FAIL il_ch1: got %h want 22", dout); end
    drain_all();
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 16; i++) clk_cycle(1'b1, 3, 8'($urandom), 1'b0, 3);
    clk_cycle(1'b1, 3, 8'h5A, 1'b1, 3);
    n_vec++; if ({wr_ovf, rd_udf, full, almost_full} !== {1'b1, 1'b0, 4'b0000, 4'b1000}) begin n_err++; $display("FAIL sc_full: got %b want %b", {wr_ovf, rd_udf, full, almost_full}, {1'b1, 1'b0, 4'b0000, 4'b1000}); end
    n_vec++; if (cnt !== m_cnt()) begin n_err++; $display("FAIL sc_full_cnt: got %h want %h", cnt, m_cnt()); end
    clk_cycle(1'b1, 1, 8'h77, 1'b1, 1);
    n_vec++; if ({wr_ovf, rd_udf, empty[1]} !== 3'b010) begin n_err++; $display("FAIL sc_empty: got %b want 010", {wr_ovf, rd_udf, empty[1]}); end
    n_vec++; if (cnt !== m_cnt()) begin n_err++; $display("FAIL sc_empty_cnt: got %h want %h", cnt, m_cnt()); end
    n_vec++; if (dout !== 8'h77) begin n_err++; $display("FAIL sc_empty_data: got %h want 77", dout); end
    drain_all();
  endtask

  task automatic test_wrap();
    int wcnt, rcnt, k;
    logic we, re;
    wcnt = 0; rcnt = 0; k = 0;
    while ((wcnt < 40 || rcnt < 40) && k < 500) begin
      we = (wcnt < 40) && ($urandom_range(3) != 0);
      re = (rcnt < 40) && ($urandom_range(2) != 0) && (mq[1].size() > 0);
      if (we && mq[1].size() < DEPTH) wcnt++;
      if (re) rcnt++;
      clk_cycle(we, 1, 8'($urandom), re, 1);
      n_vec++; if ({dout, dout_vld} !== {m_fwft_dout(), m_fwft_vld()}) begin n_err++; $display("FAIL wrap_dout: got %h want %h", {dout, dout_vld}, {m_fwft_dout(), m_fwft_vld()}); end
      n_vec++; if ({full, empty} !== {m_flags()[15:12], m_flags()[7:4]}) begin n_err++; $display("FAIL wrap_flags: got %b want %b", {full, empty}, {m_flags()[15:12], m_flags()[7:4]}); end
      k++;
    end
    n_vec++; if (rcnt !== 40) begin n_err++; $display("FAIL wrap_budget: got %0d reads want 40", rcnt); end
    drain_all();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) clk_cycle(1'b1, 0, 8'(i + 1), 1'b0, 0);
    for (int i = 0; i < 3; i++) clk_cycle(1'b1, 2, 8'(i + 9), 1'b0, 0);
    idle(1);
    n_vec++; if (cnt !== m_cnt()) begin n_err++; $display("FAIL rm_cnt7: got %h want %h", cnt, m_cnt()); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({full, almost_full, empty, almost_empty} !== 16'hFFFF) begin n_err++; $display("FAIL rm_flags: got %h want ffff", {full, almost_full, empty, almost_empty}); end
    n_vec++; if ({cnt, dout, dout_vld, r_dout, r_dout_vld, wr_ovf, rd_udf} !== 40'h0) begin n_err++; $display("FAIL rm_outs: got %h want 0", {cnt, dout, dout_vld, r_dout, r_dout_vld, wr_ovf, rd_udf}); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle(1'b0, 0, 8'h00, 1'b1, 0);
    n_vec++; if ({rd_udf, empty} !== 5'b1_1111) begin n_err++; $display("FAIL rm_after: got %b want 11111", {rd_udf, empty}); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      clk_cycle(1'($urandom_range(9) < 6), int'($urandom_range(3)), 8'($urandom),
                1'($urandom_range(9) < 5), int'($urandom_range(3)));
      n_vec++; if ({full, almost_full, empty, almost_empty} !== m_flags()) begin n_err++; $display("FAIL rnd_flags: got %h want %h", {full, almost_full, empty, almost_empty}, m_flags()); end
      n_vec++; if (cnt !== m_cnt()) begin n_err++; $display("FAIL rnd_cnt: got %h want %h", cnt, m_cnt()); end
      n_vec++; if ({dout, dout_vld} !== {m_fwft_dout(), m_fwft_vld()}) begin n_err++; $display("FAIL rnd_fwft: got %h want %h", {dout, dout_vld}, {m_fwft_dout(), m_fwft_vld()}); end
      n_vec++; if ({r_dout, r_dout_vld} !== {m_last, m_vld_r}) begin n_err++; $display("FAIL rnd_reg: got %h want %h", {r_dout, r_dout_vld}, {m_last, m_vld_r}); end
      n_vec++; if ({wr_ovf, rd_udf, r_wr_ovf, r_rd_udf} !== {m_ovf, m_udf, m_ovf, m_udf}) begin n_err++; $display("FAIL rnd_err: got %b want %b", {wr_ovf, rd_udf, r_wr_ovf, r_rd_udf}, {m_ovf, m_udf, m_ovf, m_udf}); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_ch2();
    test_interleave();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
